twf_mul_pipe: RTL and testbench
===============================

// Module: twf_mul_pipe
// PURPOSE
//  Parametrised, pipelined complex twiddle multiplier for the radix-2 FFT datapath. Per beat it
//  multiplies LANES complex samples by twiddles W_N^k and renormalises the result. k comes from an
//  internal address generator (base + stride), not from an external address.
//  Adds valid/ready flow control, round+saturate to DOUT_WIDTH, a conjugate (IFFT) mode and a bypass mode.
// PARAMETERS
//  WIDTH       14   input sample width, signed <7.6>
//  TWF_WIDTH   9    twiddle width, signed <2.7>
//  TWF_FRAC    7    twiddle fractional bits; product shifted right by this
//  DOUT_WIDTH  14   output width, signed, same format as input
//  LANES       16   complex samples per beat
//  ADDR_WIDTH  9    twiddle index width; N = 2**ADDR_WIDTH
// PORTS
//  clk          in   1                     clock, rising edge
//  rst_n        in   1                     asynchronous active-low reset
//  frame_start  in   1                     load base index from cfg_base; clear sat_flag
//  cfg_base     in   ADDR_WIDTH            first twiddle index of the frame
//  cfg_stride   in   ADDR_WIDTH            index step between lanes (and beats)
//  cfg_mode     in   2                     0 normal, 1 conjugate W*, 2 bypass (W=1), 3 = 0
//  in_valid     in   1                     input beat valid
//  in_ready     out  1                     input beat accepted when in_valid & in_ready
//  din_r/din_q  in   WIDTH x [LANES]       real/imag input per lane
//  out_valid    out  1                     output beat valid
//  out_ready    in   1                     downstream accepts
//  dout_r/dout_q out DOUT_WIDTH x [LANES]  real/imag product per lane
//  sat_flag     out  1                     sticky: any lane saturated since last frame_start
// BEHAVIOUR
//  - Reset: all stage valids 0, out_valid 0, dout_* 0, sat_flag 0, base index 0; in_ready 1.
//    Reset asserted mid-frame discards all in-flight beats; no output after release until new input.
//  - Twiddle LUT built at elaboration: TR[k] = round(2^TWF_FRAC*cos(2pi*k/N)),
//    TQ[k] = round(-2^TWF_FRAC*sin(2pi*k/N)); TR[0] = 128. Conj mode negates TQ. Bypass uses TR=2^TWF_FRAC, TQ=0.
//  - Lane i index = (base + i*cfg_stride) mod N. Wrap-around is silent.
//  - After each accepted beat, base += LANES*cfg_stride (mod N).
//  - frame_start in the same cycle as an accepted beat: that beat uses cfg_base; base then becomes
//    cfg_base + LANES*cfg_stride.
//  - cfg_mode and cfg_stride are sampled per accepted beat (registered with the data in S1).
//  - Pipeline, all stages advance on adv = ~out_valid | out_ready:
//    S1: register din, twiddles, mode.
//    S2: four signed products, full width WIDTH+TWF_WIDTH.
//    S3: re = Pr*Tr - Pq*Tq; im = Pq*Tr + Pr*Tq (one guard bit); add 2^(TWF_FRAC-1);
//        arithmetic shift right by TWF_FRAC (round half up); saturate to DOUT_WIDTH -> dout.
//  - in_ready = adv. Latency is 3 cycles from accept to out_valid when adv stays 1.
//  - Bubbles propagate as invalid stages; they are not compressed.
//  - Stall (out_ready=0 with out_valid=1): every stage and dout hold. No beat is lost, duplicated
//    or reordered. dout is stable while out_valid & ~out_ready.
//  - Saturation: result > 2^(DOUT_WIDTH-1)-1 clamps to the max, < -2^(DOUT_WIDTH-1) clamps to the min.
//    sat_flag is set when the beat leaves S3.
//  - frame_start clears sat_flag. A saturation in the same cycle wins: flag ends at 1.
//  - In-flight beats complete with the mode and indices they were accepted with.
// TESTING
//  T1 k=0, mode 0: din=(100,-50) all lanes -> dout=(100,-50) exactly 3 cycles after accept.
//  T2 cfg_base=128, stride=0 (W=-j): din=(100,0) -> dout=(0,-100).
//     Same beat in mode 1 -> dout=(0,100).
//  T3 cfg_base=64, stride=0 (TR=91, TQ=-91): din=(8191,-8191) -> dout=(0,-8192).
//     sat_flag=1; next frame_start clears it.
//  T4 LANES=4, cfg_base=510, stride=1: lane indices 510,511,0,1.
//     Next beat uses 2,3,4,5. Check against the LUT model.
//  T5 continuous in_valid over 20 beats; out_ready low on cycles 5-9 and randomly 50% elsewhere:
//     in_ready tracks adv; output sequence equals the model, in order, with no loss or duplicates.
//  T6 rst_n pulsed low mid-stream with 3 beats in flight: out_valid=0 and dout=0 immediately.
//     After release, first output matches the first post-reset input.

Source files
------------

// File: rtl/twf_mul_pipe.sv
// Pipelined complex twiddle multiplier: LANES samples per beat times W_N^k from an internal
// base+stride index generator, with valid/ready flow control, round+saturate, conj and bypass.
module twf_mul_pipe #(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned TWF_WIDTH  = 9,
  parameter int unsigned TWF_FRAC   = 7,
  parameter int unsigned DOUT_WIDTH = 14,
  parameter int unsigned LANES      = 16,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_frame_start,
  input  logic [ADDR_WIDTH-1:0]        i_cfg_base,
  input  logic [ADDR_WIDTH-1:0]        i_cfg_stride,
  input  logic [1:0]                   i_cfg_mode,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic signed [WIDTH-1:0]      i_din_r [LANES],
  input  logic signed [WIDTH-1:0]      i_din_q [LANES],
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic signed [DOUT_WIDTH-1:0] o_dout_r [LANES],
  output logic signed [DOUT_WIDTH-1:0] o_dout_q [LANES],
  output logic                         o_sat_flag
);

  localparam int unsigned N  = 1 << ADDR_WIDTH;
  localparam int unsigned PW = WIDTH + TWF_WIDTH;
  localparam real         PI = 3.14159265358979323846;

  localparam logic signed [TWF_WIDTH-1:0] TWF_ONE = TWF_WIDTH'(1 << TWF_FRAC);
  localparam logic signed [PW:0] RND  = (PW+1)'(1 << (TWF_FRAC - 1));
  localparam logic signed [PW:0] DMAX = (PW+1)'((1 << (DOUT_WIDTH - 1)) - 1);
  localparam logic signed [PW:0] DMIN = (PW+1)'(-(1 << (DOUT_WIDTH - 1)));

  // Elaboration-time twiddle value: cos for real part, -sin for imaginary part.
  function automatic int f_twf(input int k, input bit is_q);
    real ang;
    real val;
    ang = 2.0 * PI * real'(k) / real'(N);
    if (is_q) val = -(2.0 ** TWF_FRAC) * $sin(ang);
    else      val = (2.0 ** TWF_FRAC) * $cos(ang);
    return $rtoi($floor(val + 0.5));
  endfunction

  logic signed [TWF_WIDTH-1:0] w_lut_tr [N];
  logic signed [TWF_WIDTH-1:0] w_lut_tq [N];

  for (genvar k = 0; k < N; k++) begin : g_lut
    localparam int TR_K = f_twf(k, 1'b0);
    localparam int TQ_K = f_twf(k, 1'b1);
    assign w_lut_tr[k] = TWF_WIDTH'(TR_K);
    assign w_lut_tq[k] = TWF_WIDTH'(TQ_K);
  end

  logic                  w_adv;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_base_eff;
  logic [ADDR_WIDTH-1:0] w_base_nxt;
  logic [ADDR_WIDTH-1:0] r_base;

  assign w_adv       = ~o_out_valid | i_out_ready;
  assign o_in_ready  = w_adv;
  assign w_accept    = i_in_valid & w_adv;
  assign w_base_eff  = i_frame_start ? i_cfg_base : r_base;

  always_comb begin
    w_base_nxt = r_base;
    if (w_accept) begin
      w_base_nxt = w_base_eff + ADDR_WIDTH'(LANES) * i_cfg_stride;
    end else if (i_frame_start) begin
      w_base_nxt = i_cfg_base;
    end
  end

  // Per-lane twiddle selection with the mode applied before registering.
  logic [ADDR_WIDTH-1:0]       w_idx [LANES];
  logic signed [TWF_WIDTH-1:0] w_tr  [LANES];
  logic signed [TWF_WIDTH-1:0] w_tq  [LANES];

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      w_idx[i] = w_base_eff + ADDR_WIDTH'(i) * i_cfg_stride;
      w_tr[i]  = w_lut_tr[w_idx[i]];
      w_tq[i]  = w_lut_tq[w_idx[i]];
      case (i_cfg_mode)
        2'd1:    w_tq[i] = -w_lut_tq[w_idx[i]];
        2'd2: begin
          w_tr[i] = TWF_ONE;
          w_tq[i] = '0;
        end
        default: ;
      endcase
    end
  end

  logic                        r_v1, r_v2;
  logic signed [WIDTH-1:0]     r_dr1 [LANES];
  logic signed [WIDTH-1:0]     r_dq1 [LANES];
  logic signed [TWF_WIDTH-1:0] r_tr1 [LANES];
  logic signed [TWF_WIDTH-1:0] r_tq1 [LANES];
  logic signed [PW-1:0]        r_prr [LANES];
  logic signed [PW-1:0]        r_pqq [LANES];
  logic signed [PW-1:0]        r_pqr [LANES];
  logic signed [PW-1:0]        r_prq [LANES];

  // S3 combinational: combine, round half up, shift, saturate.
  logic signed [PW:0]           w_re    [LANES];
  logic signed [PW:0]           w_im    [LANES];
  logic signed [DOUT_WIDTH-1:0] w_out_r [LANES];
  logic signed [DOUT_WIDTH-1:0] w_out_q [LANES];
  logic                         w_sat_any;

  always_comb begin
    w_sat_any = 1'b0;
    for (int i = 0; i < int'(LANES); i++) begin
      w_re[i] = ((PW+1)'(r_prr[i]) - (PW+1)'(r_pqq[i]) + RND) >>> TWF_FRAC;
      w_im[i] = ((PW+1)'(r_pqr[i]) + (PW+1)'(r_prq[i]) + RND) >>> TWF_FRAC;
      w_out_r[i] = DOUT_WIDTH'(w_re[i]);
      w_out_q[i] = DOUT_WIDTH'(w_im[i]);
      if (w_re[i] > DMAX) begin
        w_out_r[i] = DOUT_WIDTH'(DMAX);
        w_sat_any  = 1'b1;
      end else if (w_re[i] < DMIN) begin
        w_out_r[i] = DOUT_WIDTH'(DMIN);
        w_sat_any  = 1'b1;
      end
      if (w_im[i] > DMAX) begin
        w_out_q[i] = DOUT_WIDTH'(DMAX);
        w_sat_any  = 1'b1;
      end else if (w_im[i] < DMIN) begin
        w_out_q[i] = DOUT_WIDTH'(DMIN);
        w_sat_any  = 1'b1;
      end
    end
  end

  logic w_sat_nxt;
  assign w_sat_nxt = (o_sat_flag & ~i_frame_start) | (w_adv & r_v2 & w_sat_any);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base      <= '0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      o_out_valid <= 1'b0;
      o_sat_flag  <= 1'b0;
      for (int i = 0; i < int'(LANES); i++) begin
        r_dr1[i]    <= '0;
        r_dq1[i]    <= '0;
        r_tr1[i]    <= '0;
        r_tq1[i]    <= '0;
        r_prr[i]    <= '0;
        r_pqq[i]    <= '0;
        r_pqr[i]    <= '0;
        r_prq[i]    <= '0;
        o_dout_r[i] <= '0;
        o_dout_q[i] <= '0;
      end
    end else begin
      r_base     <= w_base_nxt;
      o_sat_flag <= w_sat_nxt;
      if (w_adv) begin
        r_v1        <= i_in_valid;
        r_v2        <= r_v1;
        o_out_valid <= r_v2;
        for (int i = 0; i < int'(LANES); i++) begin
          r_dr1[i]    <= i_din_r[i];
          r_dq1[i]    <= i_din_q[i];
          r_tr1[i]    <= w_tr[i];
          r_tq1[i]    <= w_tq[i];
          r_prr[i]    <= PW'(r_dr1[i]) * PW'(r_tr1[i]);
          r_pqq[i]    <= PW'(r_dq1[i]) * PW'(r_tq1[i]);
          r_pqr[i]    <= PW'(r_dq1[i]) * PW'(r_tr1[i]);
          r_prq[i]    <= PW'(r_dr1[i]) * PW'(r_tq1[i]);
          o_dout_r[i] <= w_out_r[i];
          o_dout_q[i] <= w_out_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_twf_mul_pipe.sv
// Scoreboard bench for twf_mul_pipe: directed beats push expectations, a monitor pops and
// compares each handshaken output beat.
module tb_twf_mul_pipe;
  localparam int W  = 14;
  localparam int DW = 14;
  localparam int L  = 4;
  localparam int AW = 9;
  localparam int N  = 512;

  typedef logic [2*L*DW-1:0] beat_t;
  typedef logic [2*L*W-1:0]  din_t;

  logic                 clk, rst_n;
  logic                 frame_start;
  logic [AW-1:0]        cfg_base, cfg_stride;
  logic [1:0]           cfg_mode;
  logic                 in_valid, in_ready, out_valid, out_ready, sat_flag;
  logic signed [W-1:0]  din_r [L];
  logic signed [W-1:0]  din_q [L];
  logic signed [DW-1:0] dout_r [L];
  logic signed [DW-1:0] dout_q [L];

  twf_mul_pipe #(
    .WIDTH(W), .TWF_WIDTH(9), .TWF_FRAC(7), .DOUT_WIDTH(DW), .LANES(L), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start), .i_cfg_base(cfg_base),
    .i_cfg_stride(cfg_stride), .i_cfg_mode(cfg_mode), .i_in_valid(in_valid),
    .o_in_ready(in_ready), .i_din_r(din_r), .i_din_q(din_q), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_dout_r(dout_r), .o_dout_q(dout_q), .o_sat_flag(sat_flag)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    or_mode = 0;
  int    t5_cyc = 0;
  beat_t exp_q[$];
  int    lat_q[$];
  int    m_tr[N];
  int    m_tq[N];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (or_mode == 1) begin
        out_ready = (t5_cyc >= 5 && t5_cyc <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
        t5_cyc++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  function automatic beat_t cur_beat();
    beat_t b;
    for (int i = 0; i < L; i++) begin
      b[i*DW +: DW]     = dout_r[i];
      b[(L+i)*DW +: DW] = dout_q[i];
    end
    return b;
  endfunction

  function automatic beat_t rep(input int r, input int q);
    beat_t b;
    for (int i = 0; i < L; i++) begin
      b[i*DW +: DW]     = DW'(r);
      b[(L+i)*DW +: DW] = DW'(q);
    end
    return b;
  endfunction

  function automatic din_t drep(input int r, input int q);
    din_t d;
    for (int i = 0; i < L; i++) begin
      d[i*W +: W]     = W'(r);
      d[(L+i)*W +: W] = W'(q);
    end
    return d;
  endfunction

  function automatic int sat(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic beat_t model(input din_t d, input int base, input int stride, input int mode);
    beat_t b;
    int dr, dq, k, tr, tq, re, im;
    for (int i = 0; i < L; i++) begin
      dr = $signed(d[i*W +: W]);
      dq = $signed(d[(L+i)*W +: W]);
      k  = (base + i * stride) % N;
      tr = m_tr[k];
      tq = m_tq[k];
      if (mode == 1) tq = -tq;
      if (mode == 2) begin
        tr = 128;
        tq = 0;
      end
      re = sat((dr * tr - dq * tq + 64) >>> 7);
      im = sat((dq * tr + dr * tq + 64) >>> 7);
      b[i*DW +: DW]     = DW'(re);
      b[(L+i)*DW +: DW] = DW'(im);
    end
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: consumes a beat whenever out_valid & out_ready will handshake at the next edge.
  initial begin
    beat_t e, cur, prev;
    int    l;
    bit    prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      cur = cur_beat();
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_adv", int'(in_ready), int'(!out_valid || out_ready));
        if (prev_stall && out_valid) begin
          checks++;
          if (cur !== prev) begin
            errors++;
            $display("FAIL stall_hold got %h expected %h", cur, prev);
          end
        end
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got %h expected none", cur);
          end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL beat_data got %h expected %h", cur, e);
            end
            if (l >= 0) chk("latency", cyc, l);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev = cur;
      end
    end
  end

  task automatic send(input bit fs, input int base, input int stride, input int mode,
                      input din_t d, input beat_t exp, input bit chk_lat);
    bit done;
    done = 1'b0;
    @(negedge clk);
    frame_start = fs;
    cfg_base    = AW'(base);
    cfg_stride  = AW'(stride);
    cfg_mode    = 2'(mode);
    in_valid    = 1'b1;
    for (int i = 0; i < L; i++) begin
      din_r[i] = d[i*W +: W];
      din_q[i] = d[(L+i)*W +: W];
    end
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(exp);
        lat_q.push_back(chk_lat ? cyc + 3 : -1);
        done = 1'b1;
      end
      @(posedge clk);
      if (!done) @(negedge clk);
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid    = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    din_t  d;
    beat_t e;
    int    m;
    for (int k = 0; k < N; k++) begin
      m_tr[k] = $rtoi($floor(128.0 * $cos(2.0 * 3.14159265358979 * k / N) + 0.5));
      m_tq[k] = $rtoi($floor(-128.0 * $sin(2.0 * 3.14159265358979 * k / N) + 0.5));
    end
    rst_n = 1'b0;
    frame_start = 1'b0;
    cfg_base = '0;
    cfg_stride = '0;
    cfg_mode = '0;
    in_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      din_r[i] = '0;
      din_q[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_dout_zero", int'(cur_beat() == '0), 1);
    rst_n = 1'b1;

    // T1: k=0 identity, exact 3-cycle latency
    send(1, 0, 0, 0, drep(100, -50), rep(100, -50), 1);
    idle();
    drain();

    // T2: W=-j, then conjugate
    send(1, 128, 0, 0, drep(100, 0), rep(0, -100), 1);
    send(1, 128, 0, 1, drep(100, 0), rep(0, 100), 1);
    idle();
    drain();
    chk("sat_before_t3", int'(sat_flag), 0);

    // T3: saturation on the imaginary part, then clear by frame_start
    send(1, 64, 0, 0, drep(8191, -8191), rep(0, -8192), 1);
    idle();
    drain();
    chk("sat_set", int'(sat_flag), 1);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    #1;
    chk("sat_cleared", int'(sat_flag), 0);

    // T4: index wrap 510,511,0,1 then 2..5 from the advanced base
    for (int i = 0; i < L; i++) begin
      d[i*W +: W]     = W'(1000 + 300 * i);
      d[(L+i)*W +: W] = W'(-2000 + 777 * i);
    end
    send(1, 510, 1, 0, d, model(d, 510, 1, 0), 1);
    send(0, 0, 1, 0, d, model(d, 2, 1, 0), 1);
    idle();
    drain();

    // T5: 20 continuous beats with backpressure, mixed modes
    or_mode = 1;
    t5_cyc = 0;
    m = 5;
    for (int b = 0; b < 20; b++) begin
      for (int i = 0; i < L; i++) begin
        d[i*W +: W]     = W'(((b * 2731 + i * 1013 + 17) % 16384) - 8192);
        d[(L+i)*W +: W] = W'(((b * 1877 + i * 733 + 5) % 16384) - 8192);
      end
      e = model(d, m, 3, b % 4);
      send(b == 0, 5, 3, b % 4, d, e, 0);
      m = (m + L * 3) % N;
    end
    idle();
    drain();
    or_mode = 0;
    repeat (2) @(negedge clk);

    // T6: reset with beats in flight
    send(1, 7, 1, 0, drep(500, 400), model(drep(500, 400), 7, 1, 0), 0);
    send(0, 0, 1, 0, drep(600, 300), model(drep(600, 300), 11, 1, 0), 0);
    send(0, 0, 1, 0, drep(700, 200), model(drep(700, 200), 15, 1, 0), 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(out_valid), 0);
    chk("t6_rst_dout", int'(cur_beat() == '0), 1);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      #1;
      chk("t6_no_output", int'(out_valid), 0);
    end
    send(0, 0, 0, 0, drep(123, -77), rep(123, -77), 1);
    idle();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
